// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive deframer.
// Holds the receive state encoding, the preamble/SFD byte values, the
// Ethernet FCS residue constant and the bit positions of the in-band
// status nibble that is sent between frames.
package rgmii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    // Non-reflected form of the good-frame CRC-32 residue.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // In-band status nibble layout (rx_d_rise while DV is low).
    localparam int ST_LINK     = 0;
    localparam int ST_SPEED_LO = 1;
    localparam int ST_SPEED_HI = 2;
    localparam int ST_DUPLEX   = 3;

    // The CRC register shifts LSB-first, so its contents are the bit
    // reversal of the non-reflected residue above.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            bitrev32[i] = v[31-i];
        end
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 update (reflected polynomial 0xEDB88320, LSB first).
// Purely combinational; compiled only when RGMII_RX_FCS_CHECK_EN is defined.
// Ports:
//   crc_in  - current CRC register
//   data    - byte to fold in, bit 0 first
//   crc_out - CRC register after the byte
`ifdef RGMII_RX_FCS_CHECK_EN
module crc32_d8 (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    localparam logic [31:0] POLY = 32'hEDB88320;

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out[0] ^ data[i]) ? ((crc_out >> 1) ^ POLY) : (crc_out >> 1);
        end
    end
endmodule
`endif

// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer.
// Rebuilds bytes from IDDR rise/fall nibbles, debounces the in-band link
// status sent between frames, strips preamble/SFD, checks frame length and
// emits a BEATS-byte-wide stream with sof/eof/err flags and saturating
// good/bad frame counters.
// Optional build macro: RGMII_RX_FCS_CHECK_EN adds a CRC-32 FCS check whose
// failure is folded into m_err and frames_err.
// Ports:
//   clk, reset_n              - receive clock, async active-low reset
//   rx_d_rise / rx_d_fall     - low / high nibble of each received byte
//   rx_ctl_rise / rx_ctl_fall - DV and DV^ER samples of RX_CTL
//   m_data, m_keep            - output word (byte 0 in [7:0]) and byte mask
//   m_valid, m_sof, m_eof     - word strobe and frame delimiters
//   m_err                     - frame bad, valid with m_eof
//   link_up, speed, full_duplex - debounced in-band status
//   frames_ok, frames_err     - saturating frame counters
module rgmii_rx_deframer
    import rgmii_pkg::*;
#(
    parameter int BEATS         = 1,
    parameter int CNT_W         = 16,
    parameter int STATUS_STABLE = 4,
    parameter int MIN_FRAME     = 64,
    parameter int MAX_FRAME     = 1522
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           rx_d_rise,
    input  logic [3:0]           rx_d_fall,
    input  logic                 rx_ctl_rise,
    input  logic                 rx_ctl_fall,
    output logic [8*BEATS-1:0]   m_data,
    output logic [BEATS-1:0]     m_keep,
    output logic                 m_valid,
    output logic                 m_sof,
    output logic                 m_eof,
    output logic                 m_err,
    output logic                 link_up,
    output logic [1:0]           speed,
    output logic                 full_duplex,
    output logic [CNT_W-1:0]     frames_ok,
    output logic [CNT_W-1:0]     frames_err
);
    localparam int LEN_W  = $clog2(MAX_FRAME + 2);
    localparam int HCNT_W = $clog2(BEATS + 1);
    localparam int DBN_W  = $clog2(STATUS_STABLE + 1);

    rx_state_t           state;
    logic [7:0]          rx_byte;
    logic                dv;
    logic                er;
    logic [8*BEATS-1:0]  hold;
    logic [HCNT_W-1:0]   hold_cnt;
    logic [HCNT_W-1:0]   hold_slot;
    logic                hold_wr;
    logic [LEN_W-1:0]    frame_len;
    logic                err_acc;
    logic                first_word;
    logic                sfd_seen;
    logic                fcs_bad;
    logic                end_err;
    logic [3:0]          st_prev;
    logic [DBN_W-1:0]    st_cnt;
    logic [DBN_W-1:0]    st_cnt_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [BEATS-1:0] keep_mask(input logic [HCNT_W-1:0] n);
        keep_mask = '0;
        for (int i = 0; i < BEATS; i++) begin
            keep_mask[i] = (i < int'(n));
        end
    endfunction

    assign rx_byte  = {rx_d_fall, rx_d_rise};
    assign dv       = rx_ctl_rise;
    assign er       = rx_ctl_rise ^ rx_ctl_fall;
    assign sfd_seen = (state == IDLE || state == PREAMBLE) && dv && (rx_byte == SFD_BYTE);

    // The byte that would push the length past MAX_FRAME is not stored: the
    // holding word is closed out with it instead.
    assign hold_wr   = (state == DATA) && dv && (frame_len != LEN_W'(MAX_FRAME));
    assign hold_slot = (hold_cnt == HCNT_W'(BEATS)) ? '0 : hold_cnt;

    always_comb begin
        st_cnt_nxt = DBN_W'(1);
        if (rx_d_rise == st_prev) begin
            st_cnt_nxt = (st_cnt == DBN_W'(STATUS_STABLE)) ? st_cnt : st_cnt + 1'b1;
        end
    end

`ifdef RGMII_RX_FCS_CHECK_EN
    logic [31:0] crc;
    logic [31:0] crc_nxt;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (rx_byte),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (sfd_seen) begin
            crc <= '1;
        end else if (state == DATA && dv) begin
            crc <= crc_nxt;
        end
    end

    assign fcs_bad = (bitrev32(crc) != CRC_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    assign end_err = err_acc | (frame_len < LEN_W'(MIN_FRAME)) | fcs_bad;

    // Byte assembly stage: holding word, written slot by slot.
    always_ff @(posedge clk) begin
        if (hold_wr) begin
            hold[8*int'(hold_slot) +: 8] <= rx_byte;
        end
    end

    // Control / output stage. A full word leaves only when the next byte
    // shows the frame continues, so eof always lands on the true last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            frame_len   <= '0;
            err_acc     <= 1'b0;
            first_word  <= 1'b0;
            st_prev     <= '0;
            st_cnt      <= '0;
            m_data      <= '0;
            m_keep      <= '0;
            m_valid     <= 1'b0;
            m_sof       <= 1'b0;
            m_eof       <= 1'b0;
            m_err       <= 1'b0;
            link_up     <= 1'b0;
            speed       <= 2'b00;
            full_duplex <= 1'b0;
            frames_ok   <= '0;
            frames_err  <= '0;
        end else begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            m_err   <= 1'b0;
            m_keep  <= '0;

            if (sfd_seen) begin
                frame_len  <= '0;
                err_acc    <= 1'b0;
                hold_cnt   <= '0;
                first_word <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!dv) begin
                        st_prev <= rx_d_rise;
                        st_cnt  <= st_cnt_nxt;
                        if (st_cnt_nxt == DBN_W'(STATUS_STABLE)) begin
                            link_up     <= rx_d_rise[ST_LINK];
                            speed       <= rx_d_rise[ST_SPEED_HI:ST_SPEED_LO];
                            full_duplex <= rx_d_rise[ST_DUPLEX];
                        end
                    end else if (rx_byte == PREAMBLE_BYTE) begin
                        state <= PREAMBLE;
                    end else if (sfd_seen) begin
                        state <= DATA;
                    end else begin
                        state      <= DROP;
                        frames_err <= sat_inc(frames_err);
                    end
                end

                PREAMBLE: begin
                    if (!dv) begin
                        state      <= IDLE;
                        frames_err <= sat_inc(frames_err);
                    end else if (sfd_seen) begin
                        state <= DATA;
                    end else if (rx_byte != PREAMBLE_BYTE) begin
                        state      <= DROP;
                        frames_err <= sat_inc(frames_err);
                    end
                end

                DATA: begin
                    if (!dv) begin
                        m_valid <= 1'b1;
                        m_data  <= hold;
                        m_keep  <= keep_mask(hold_cnt);
                        m_sof   <= first_word;
                        m_eof   <= 1'b1;
                        m_err   <= end_err;
                        if (end_err) begin
                            frames_err <= sat_inc(frames_err);
                        end else begin
                            frames_ok <= sat_inc(frames_ok);
                        end
                        state <= IDLE;
                    end else if (!hold_wr) begin
                        m_valid    <= 1'b1;
                        m_data     <= hold;
                        m_keep     <= keep_mask(hold_cnt);
                        m_sof      <= first_word;
                        m_eof      <= 1'b1;
                        m_err      <= 1'b1;
                        frames_err <= sat_inc(frames_err);
                        frame_len  <= LEN_W'(MAX_FRAME + 1);
                        state      <= DROP;
                    end else begin
                        frame_len <= frame_len + 1'b1;
                        err_acc   <= err_acc | er;
                        if (hold_cnt == HCNT_W'(BEATS)) begin
                            m_valid    <= 1'b1;
                            m_data     <= hold;
                            m_keep     <= '1;
                            m_sof      <= first_word;
                            first_word <= 1'b0;
                            hold_cnt   <= HCNT_W'(1);
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end

                DROP: begin
                    if (!dv) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
`timescale 1ns/1ps
module tb_rgmii_rx_deframer;
    localparam int BEATS = 4;
    localparam int CNT_W = 16;
`ifdef RGMII_RX_FCS_CHECK_EN
    localparam logic FCS_ON = 1'b1;
`else
    localparam logic FCS_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n;
    logic [3:0]          rx_d_rise;
    logic [3:0]          rx_d_fall;
    logic                rx_ctl_rise;
    logic                rx_ctl_fall;
    logic [8*BEATS-1:0]  m_data;
    logic [BEATS-1:0]    m_keep;
    logic                m_valid;
    logic                m_sof;
    logic                m_eof;
    logic                m_err;
    logic                link_up;
    logic [1:0]          speed;
    logic                full_duplex;
    logic [CNT_W-1:0]    frames_ok;
    logic [CNT_W-1:0]    frames_err;

    always #5 clk = ~clk;

    rgmii_rx_deframer #(
        .BEATS         (BEATS),
        .CNT_W         (CNT_W),
        .STATUS_STABLE (4),
        .MIN_FRAME     (64),
        .MAX_FRAME     (1522)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_d_rise   (rx_d_rise),
        .rx_d_fall   (rx_d_fall),
        .rx_ctl_rise (rx_ctl_rise),
        .rx_ctl_fall (rx_ctl_fall),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_valid     (m_valid),
        .m_sof       (m_sof),
        .m_eof       (m_eof),
        .m_err       (m_err),
        .link_up     (link_up),
        .speed       (speed),
        .full_duplex (full_duplex),
        .frames_ok   (frames_ok),
        .frames_err  (frames_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        sof;
        logic        eof;
        logic        err;
    } word_t;

    word_t      words[$];
    logic [7:0] fb [0:1599];
    logic [3:0] idle_nib = 4'h0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_ok = 0;
    int         exp_err = 0;

    // Output capture on the inactive edge.
    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            words.push_back('{data: m_data, keep: m_keep, sof: m_sof, eof: m_eof, err: m_err});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] b, input logic dv, input logic er);
        rx_d_rise   = b[3:0];
        rx_d_fall   = b[7:4];
        rx_ctl_rise = dv;
        rx_ctl_fall = dv ^ er;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc({4'h0, idle_nib}, 1'b0, 1'b0);
        end
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 1600; i++) begin
            fb[i] = 8'(i);
        end
    endtask

    task automatic send_frame(input int len, input int er_at);
        words.delete();
        repeat (7) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) begin
            cyc(fb[i], 1'b1, (i == er_at));
        end
        idle(4);
    endtask

    task automatic check_frame(input string tag, input int nw, input logic [3:0] keep,
                               input logic [7:0] lo, input logic err);
        int nsof = 0;
        int neof = 0;
        foreach (words[i]) begin
            nsof += int'(words[i].sof);
            neof += int'(words[i].eof);
        end
        chk({tag, ".words"}, 32'(words.size()), 32'(nw));
        chk({tag, ".sof_cnt"}, 32'(nsof), 32'd1);
        chk({tag, ".eof_cnt"}, 32'(neof), 32'd1);
        if (words.size() > 0) begin
            chk({tag, ".first_sof"}, 32'(words[0].sof), 32'd1);
            chk({tag, ".last_eof"}, 32'(words[$].eof), 32'd1);
            chk({tag, ".last_keep"}, 32'(words[$].keep), 32'(keep));
            chk({tag, ".last_byte0"}, 32'(words[$].data[7:0]), 32'(lo));
            chk({tag, ".last_err"}, 32'(words[$].err), 32'(err));
        end else begin
            chk({tag, ".nonempty"}, 32'd0, 32'd1);
        end
        if (err) exp_err++;
        else     exp_ok++;
        chk({tag, ".frames_ok"}, 32'(frames_ok), 32'(exp_ok));
        chk({tag, ".frames_err"}, 32'(frames_err), 32'(exp_err));
    endtask

`ifdef RGMII_RX_FCS_CHECK_EN
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, fb[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int neof;
        reset_n     = 1'b0;
        rx_d_rise   = 4'h0;
        rx_d_fall   = 4'h0;
        rx_ctl_rise = 1'b0;
        rx_ctl_fall = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.m_data", 32'(m_data), 32'd0);
        chk("rst.m_keep", 32'(m_keep), 32'd0);
        chk("rst.flags", 32'({m_sof, m_eof, m_err}), 32'd0);
        chk("rst.status", 32'({link_up, speed, full_duplex}), 32'd0);
        chk("rst.frames_ok", 32'(frames_ok), 32'd0);
        chk("rst.frames_err", 32'(frames_err), 32'd0);
        reset_n = 1'b1;

        // Status glitch: three samples are not enough.
        idle_nib = 4'hB;
        idle(3);
        idle_nib = 4'h0;
        idle(1);
        chk("st_glitch.link", 32'(link_up), 32'd0);
        chk("st_glitch.speed", 32'(speed), 32'd0);
        chk("st_glitch.duplex", 32'(full_duplex), 32'd0);

        // Status stable for four samples.
        idle_nib = 4'hB;
        idle(3);
        chk("st_3.link", 32'(link_up), 32'd0);
        idle(1);
        chk("st_4.link", 32'(link_up), 32'd1);
        chk("st_4.speed", 32'(speed), 32'd1);
        chk("st_4.duplex", 32'(full_duplex), 32'd1);

        fill_seq();

        send_frame(64, -1);
        check_frame("f64", 16, 4'hF, 8'h3C, FCS_ON);
        chk("f64.word0", words[0].data, 32'h03020100);
        chk("f64.word7", words[7].data, 32'h1F1E1D1C);
        chk("f64.link_kept", 32'(link_up), 32'd1);

        send_frame(65, -1);
        check_frame("f65", 17, 4'h1, 8'h40, FCS_ON);

        send_frame(64, 10);
        check_frame("f64_er", 16, 4'hF, 8'h3C, 1'b1);

        send_frame(20, -1);
        check_frame("runt20", 5, 4'hF, 8'h10, 1'b1);

        send_frame(1600, -1);
        check_frame("long1600", 381, 4'h3, 8'hF0, 1'b1);
        chk("long1600.byte1", 32'(words[$].data[15:8]), 32'hF1);

        send_frame(64, -1);
        check_frame("after_long", 16, 4'hF, 8'h3C, FCS_ON);

        // Bad first byte: dropped, SFD inside the dropped burst is ignored.
        words.delete();
        cyc(8'h12, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        repeat (3) cyc(8'h00, 1'b1, 1'b0);
        idle(3);
        exp_err++;
        chk("badstart.words", 32'(words.size()), 32'd0);
        chk("badstart.frames_err", 32'(frames_err), 32'(exp_err));

        // Preamble cut short by DV low.
        cyc(8'h55, 1'b1, 1'b0);
        cyc(8'h55, 1'b1, 1'b0);
        idle(3);
        exp_err++;
        chk("pre_abort.words", 32'(words.size()), 32'd0);
        chk("pre_abort.frames_err", 32'(frames_err), 32'(exp_err));

        // Reset in the middle of a frame.
        words.delete();
        repeat (7) cyc(8'h55, 1'b1, 1'b0);
        cyc(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(fb[i], 1'b1, 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst.m_valid", 32'(m_valid), 32'd0);
        chk("midrst.frames_ok", 32'(frames_ok), 32'd0);
        chk("midrst.frames_err", 32'(frames_err), 32'd0);
        chk("midrst.link", 32'(link_up), 32'd0);
        rx_ctl_rise = 1'b0;
        rx_ctl_fall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        neof = 0;
        foreach (words[i]) neof += int'(words[i].eof);
        chk("midrst.words_before", 32'(words.size()), 32'd2);
        chk("midrst.no_eof", 32'(neof), 32'd0);
        exp_ok  = 0;
        exp_err = 0;
        idle(2);
        send_frame(64, -1);
        check_frame("post_rst", 16, 4'hF, 8'h3C, FCS_ON);

`ifdef RGMII_RX_FCS_CHECK_EN
        begin
            logic [31:0] fcs;
            fill_seq();
            fcs = fcs_of(60);
            for (int j = 0; j < 4; j++) fb[60+j] = fcs[8*j +: 8];
            send_frame(64, -1);
            check_frame("fcs_good", 16, 4'hF, 8'h3C, 1'b0);
            fb[62] = fb[62] ^ 8'h01;
            send_frame(64, -1);
            check_frame("fcs_bad", 16, 4'hF, 8'h3C, 1'b1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_deframer.md
Name: rgmii_rx_deframer

Overview:
- Synthesizable, parametrised successor to the simulation-only RGMII/GMII shim. Consumes RGMII receive nibbles already split into rise/fall samples by the pad IDDR.
- Rebuilds bytes, decodes in-band link status, strips preamble/SFD, checks length, and emits a W-byte-wide framed stream with per-frame status and counters.
- Sits between the pad-level IDDR and the MAC receive path in the motor-controller FPGA.

Parameters:
BEATS, 1, bytes per output word (1, 2 or 4)
CNT_W, 16, width of saturating frame counters
STATUS_STABLE, 4, consecutive identical idle status samples needed before status outputs update (>=1)
MIN_FRAME, 64, minimum legal length in bytes after SFD, FCS included
MAX_FRAME, 1522, maximum legal length in bytes after SFD, FCS included

Ports:
clk  in  1  receive clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
rx_d_rise  in  4  rising-edge nibble, carries byte bits [3:0]
rx_d_fall  in  4  falling-edge nibble, carries byte bits [7:4]
rx_ctl_rise  in  1  RX_CTL rising sample (= DV)
rx_ctl_fall  in  1  RX_CTL falling sample (= DV xor ER)
m_data  out  8*BEATS  packed bytes; byte 0 in [7:0]
m_keep  out  BEATS  valid-byte mask, contiguous from bit 0
m_valid  out  1  word valid; single-cycle pulse per word, no backpressure
m_sof  out  1  first word of frame
m_eof  out  1  last word of frame
m_err  out  1  frame bad; meaningful only with m_eof
link_up  out  1  debounced in-band link
speed  out  2  debounced in-band speed (00=10M, 01=100M, 10=1G)
full_duplex  out  1  debounced in-band duplex
frames_ok  out  CNT_W  saturating count of good frames
frames_err  out  CNT_W  saturating count of bad or aborted frames

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, debounce counter 0. Reset may assert in any state. An in-flight frame is discarded with no eof.
- Per cycle: byte = {rx_d_fall, rx_d_rise}; dv = rx_ctl_rise; er = rx_ctl_rise ^ rx_ctl_fall.
- IDLE:
  - dv=0: candidate status = rx_d_rise (bit0 link, bits[2:1] speed, bit3 duplex). The debounce counter increments while the candidate equals the previous sample and resets to 1 otherwise. On reaching STATUS_STABLE, outputs take the candidate.
  - dv=1: byte 0x55 -> PREAMBLE; byte 0xD5 -> DATA (short preamble accepted); any other byte -> DROP and frames_err+1.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> DATA, length=0, err_acc=0.
  - dv=0 -> IDLE, frames_err+1.
  - other byte -> DROP, frames_err+1.
- DATA:
  - Each dv=1 byte is appended to the holding word; length+1 (saturating at MAX_FRAME+1); err_acc |= er.
  - A full word is emitted 1 clk after the next byte arrives. m_sof is set on the first word of the frame.
  - dv=0 ends the frame. The holding word (full or partial) is emitted next clk with m_eof=1 and m_keep set from the byte count.
  - m_err = err_acc | (length<MIN_FRAME).
  - frames_ok or frames_err +1 accordingly, then -> IDLE.
  - Single-word frame: m_sof and m_eof both 1.
  - Length reaching MAX_FRAME+1: the current word is emitted with m_eof=1 and m_err=1, frames_err+1, then -> DROP.
- DROP: ignore bytes until dv=0, then -> IDLE. Status is not sampled in DROP.
- Counters hold at all-ones. Status is sampled only in IDLE with dv=0.

Optional Feature:
- RGMII_RX_FCS_CHECK_EN defined: a CRC-32 (reflected, init 0xFFFFFFFF) runs over every byte after SFD. At frame end, residue != 0xC704DD7B ORs into m_err and frames_err.
- Macro absent: no CRC logic; m_err covers only ER and length violations.

Decomposition:
- Package rgmii_pkg holds:
  - state enum IDLE/PREAMBLE/DATA/DROP
  - PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_RESIDUE=0xC704DD7B
  - status bit positions
- Sub-module crc32_d8: combinational byte-wide CRC update, instantiated only under the macro.

Test Plan:
- Idle nibble 0xB held 4 clk after reset -> link_up=1, speed=01, full_duplex=1. 3 clk of 0xB then 0x0 -> outputs stay 0.
- 7x0x55, 0xD5, 64 bytes 0x00..0x3F, BEATS=4 -> 16 words; first has m_sof; last has m_eof, m_keep=1111, m_err=0; frames_ok=1.
- 65-byte frame, BEATS=4 -> last word m_keep=0001, data[7:0]=0x40, m_err=0.
- 64-byte frame with rx_ctl_fall=0 on byte 10 -> m_err=1 on eof, frames_err=1. 20-byte frame -> m_err=1 (runt).
- 1600-byte frame -> eof with m_err=1 at byte 1523; rest dropped; next valid frame received clean.
- Reset asserted mid-DATA -> outputs 0 immediately, no eof; next frame starts with m_sof. With macro, corrupt 1 FCS byte -> m_err=1.
